// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM frame reader: FSM encoding, default
// BRAM read latency and a FIFO depth sanity helper.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Must match the latency of the BRAM wrapper (addr reg, out reg, q reg).
    localparam int DEF_RD_LATENCY = 3;

    function automatic bit fifo_depth_ok(input int depth);
        return depth >= 1;
    endfunction

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Small first-word-fall-through skid FIFO that absorbs BRAM reads already in
// flight when the downstream consumer stalls.
module bram_rd_skid_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 4,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Reads LENGTH consecutive BRAM words from a base address (wrapping) and
// streams them out valid/ready with a last marker. Issue is throttled by
// credits so in-flight reads always have a FIFO slot waiting for them.
module bram_frame_reader
    import bram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int NUMWORDS   = 256,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(NUMWORDS)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int FD = fifo_depth_ok(FIFO_DEPTH) ? FIFO_DEPTH : 1;
    localparam int CW = $clog2(FD + 1);
    localparam int IW = $clog2(RD_LATENCY + 1);

    rd_state_e             state_q, state_d;
    logic [AW-1:0]         addr_q;
    logic [AW:0]           len_q, issue_cnt, out_cnt, last_idx;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [IW-1:0]         inflight_cnt;
    logic                  busy_q, done_q;
    logic                  start_acc, issue, push, pop, last_hs;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    assign last_idx  = len_q - (AW+1)'(1);
    assign start_acc = start && !busy_q;
    assign push      = vld_pipe[RD_LATENCY-1];
    assign pop       = m_valid && m_ready;
    assign last_hs   = pop && (out_cnt == last_idx);

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdaddress = addr_q;
    assign m_valid   = !fifo_empty;
    assign m_last    = m_valid && (out_cnt == last_idx);

    // Next state plus the credit-gated issue decision (a same-cycle pop frees a slot).
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc && length != '0)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                issue = (int'(inflight_cnt) + int'(fifo_cnt) - int'(pop)) < FD;
                if (issue && issue_cnt == last_idx)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_hs)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Frame parameters, address/counters, read-valid pipe and busy/done handshake.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            issue_cnt    <= '0;
            out_cnt      <= '0;
            vld_pipe     <= '0;
            inflight_cnt <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                busy_q <= 1'b1;
                done_q <= (length == '0);
                // A zero-length frame leaves the read address untouched.
                if (length != '0) begin
                    addr_q    <= base_addr;
                    len_q     <= length;
                    issue_cnt <= '0;
                    out_cnt   <= '0;
                end
            end else if (done_q) begin
                busy_q <= 1'b0;
            end else if (state_q == ST_DRAIN && last_hs) begin
                done_q <= 1'b1;
            end

            if (issue) begin
                addr_q    <= (addr_q == AW'(NUMWORDS - 1)) ? '0 : addr_q + AW'(1);
                issue_cnt <= issue_cnt + (AW+1)'(1);
            end
            if (pop)
                out_cnt <= out_cnt + (AW+1)'(1);

            vld_pipe     <= (vld_pipe << 1) | RD_LATENCY'(issue);
            inflight_cnt <= inflight_cnt + IW'(issue) - IW'(push);
        end
    end

    // Credits must make an overflowing capture impossible.
    always_ff @(posedge clock) begin
        if (rst_n)
            assert (!(push && fifo_full && !pop))
                else $error("bram_frame_reader: capture into full skid fifo");
    end

    bram_rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FD)
    ) u_skid (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .din   (q),
        .pop   (pop),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench: BRAM model with mem[i]=i and 3-cycle read latency,
// handshake monitor with stall-stability checks, frame-level comparisons.
module tb_bram_frame_reader;

    localparam int DW = 256;
    localparam int NW = 256;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, m_valid, m_last;
    logic          m_ready = 1'b1;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q, m_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] p0, p1;
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    logic          stalled = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    bram_frame_reader dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rdaddress (rdaddress),
        .q         (q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < NW; i++) mem[i] = DW'(i);

    // BRAM wrapper model: address reg, output reg, q reg.
    always @(posedge clock) begin
        p0 <= mem[rdaddress];
        p1 <= p0;
        q  <= p1;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record handshakes; a stalled word must be unchanged next cycle.
    always @(negedge clock) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, hold_d);
                chk("stall_last", m_last, hold_l);
            end
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            stalled = m_valid && !m_ready;
            hold_d  = m_data;
            hold_l  = m_last;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input int b, input int l);
        got_d.delete();
        got_l.delete();
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        step();
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: ready low
    task automatic wait_done(input string tag, input int mode, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            case (mode)
                1:       m_ready = (i % 4 == 0) || (i % 4 == 3);
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
            step();
            if (done) seen = 1;
        end
        chk({tag, "_done"}, seen, 1);
        m_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int b, input int l);
        chk({tag, "_count"}, got_d.size(), l);
        for (int k = 0; k < l && k < got_d.size(); k++) begin
            chk({tag, "_data"}, got_d[k], DW'((b + k) % NW));
            chk({tag, "_last"}, got_l[k], (k == l - 1));
        end
    endtask

    initial begin
        logic [AW-1:0] ra;

        // Reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", rdaddress, 0);
        chk("rst_data", m_data, 0);
        rst_n = 1'b1;
        step();

        // Basic frame: latency, back-to-back data, last, done timing
        m_ready = 1'b1;
        start_frame(10, 5);
        chk("basic_busy", busy, 1);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("basic_early_valid", m_valid, 0);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            chk("basic_valid", m_valid, 1);
            chk("basic_data", m_data, DW'(10 + k));
            chk("basic_last", m_last, (k == 4));
        end
        step();
        chk("basic_done", done, 1);
        chk("basic_busy_at_done", busy, 1);
        chk("basic_valid_after", m_valid, 0);
        step();
        chk("basic_done_pulse", done, 0);
        chk("basic_busy_drop", busy, 0);
        check_frame("basic", 10, 5);

        // Wrap around the top of memory
        start_frame(254, 4);
        chk("wrap_addr0", rdaddress, 254);
        step(); chk("wrap_addr1", rdaddress, 255);
        step(); chk("wrap_addr2", rdaddress, 0);
        step(); chk("wrap_addr3", rdaddress, 1);
        wait_done("wrap", 0, 40);
        check_frame("wrap", 254, 4);
        step();

        // Backpressure 1,0,0,1
        start_frame(40, 8);
        wait_done("bp", 1, 200);
        check_frame("bp", 40, 8);
        step();

        // Ready held low: only FIFO_DEPTH reads go out
        m_ready = 1'b0;
        start_frame(0, 16);
        for (int c = 0; c < 12; c++) step();
        chk("hold_rdaddr", rdaddress, 4);
        chk("hold_valid", m_valid, 1);
        chk("hold_busy", busy, 1);
        wait_done("hold", 0, 100);
        check_frame("hold", 0, 16);
        step();

        // Zero length
        ra = rdaddress;
        start_frame(7, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_valid", m_valid, 0);
        chk("zero_addr", rdaddress, ra);
        step();
        chk("zero_done_pulse", done, 0);
        chk("zero_busy_drop", busy, 0);
        chk("zero_valid2", m_valid, 0);
        chk("zero_addr2", rdaddress, ra);

        // Start while busy is ignored
        start_frame(100, 6);
        step(); step();
        start = 1'b1; base_addr = 8'd200; length = 9'd2;
        step();
        start = 1'b0;
        wait_done("ign", 0, 60);
        check_frame("ign", 100, 6);
        step();
        chk("ign_busy_drop", busy, 0);

        // Reset mid-frame, then a clean frame
        start_frame(50, 8);
        for (int i = 0; i < 20 && got_d.size() < 3; i++) step();
        chk("mid_words_seen", (got_d.size() >= 3), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_addr", rdaddress, 0);
        chk("mid_rst_data", m_data, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        start_frame(0, 2);
        wait_done("post", 0, 40);
        check_frame("post", 0, 2);
        step();
        chk("post_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
